// File: rtl/step_ctrl_pkg.sv
// Shared constants and width helpers for the step sequencer controller.
package step_ctrl_pkg;

  localparam int unsigned CLK_HZ        = 100_000_000;
  localparam int unsigned DB_MS         = 10;
  localparam int unsigned DB_CYCLES_DEF = CLK_HZ / 1000 * DB_MS;
  localparam int unsigned AUTO_DIV_DEF  = CLK_HZ;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((longint'(1) << r) < longint'(n)) r++;
    return r;
  endfunction

  // Register width for a count of n states; never narrower than one bit.
  function automatic int unsigned bits_for(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/step_sequencer_ctrl_if.sv
// Board-side signal bundle: raw buttons/switch in, counter and LED drive out.
interface step_sequencer_ctrl_if #(
  parameter int unsigned CNT_W = 2
);
  logic             btn_step;
  logic             btn_mode;
  logic             sw_clear;
  logic [CNT_W-1:0] cnt;
  logic             step;
  logic             carry;
  logic             z_led;
  logic             auto_mode;

  modport master (
    output btn_step, btn_mode, sw_clear,
    input  cnt, step, carry, z_led, auto_mode
  );

  modport slave (
    input  btn_step, btn_mode, sw_clear,
    output cnt, step, carry, z_led, auto_mode
  );
endinterface

// File: rtl/debounce_sync.sv
// 2-FF synchronizer, stability-count debouncer and rising-edge pulse for one raw input.
module debounce_sync
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned      CW      = bits_for(DB_CYCLES);
  localparam logic [CW-1:0]    CntLast = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], din};
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the input agrees with the level restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/step_sequencer_ctrl.sv
// Modulo-N step counter controller: merges manual and auto-step requests, with clear priority.
module step_sequencer_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned AUTO_DIV  = AUTO_DIV_DEF,
  parameter int unsigned CNT_MOD   = 4,
  parameter int unsigned CNT_W     = bits_for(CNT_MOD)
) (
  input logic                  clk,
  input logic                  rst,
  step_sequencer_ctrl_if.slave bus
);

  if (CNT_MOD < 2 || longint'(CNT_MOD) > (longint'(1) << CNT_W)) begin : g_bad_cnt_mod
    $error("step_sequencer_ctrl: CNT_MOD must lie in [2, 2**CNT_W]");
  end

  localparam int unsigned      PW      = bits_for(AUTO_DIV);
  localparam logic [PW-1:0]    PreLast = PW'(AUTO_DIV - 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MOD - 1);

  logic step_level, step_rise;
  logic mode_level, mode_rise;
  logic unused_levels;

  debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.btn_step),
    .level (step_level),
    .rise  (step_rise)
  );

  debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.btn_mode),
    .level (mode_level),
    .rise  (mode_rise)
  );

  assign unused_levels = step_level ^ mode_level;

  logic [1:0]       clr_sync_q;
  logic             auto_q, auto_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             carry_q, carry_d;
  logic             z_q, z_d;
  logic             clear, auto_tick, req, wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_sync_q <= '0;
      auto_q     <= 1'b0;
      presc_q    <= '0;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      carry_q    <= 1'b0;
      z_q        <= 1'b0;
    end else begin
      clr_sync_q <= {clr_sync_q[0], bus.sw_clear};
      auto_q     <= auto_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      carry_q    <= carry_d;
      z_q        <= z_d;
    end
  end

  always_comb begin
    clear     = clr_sync_q[1];
    auto_tick = auto_q && !clear && (presc_q == PreLast);
    req       = step_rise | auto_tick;
    wrap      = (cnt_q == CntLast);
    auto_d    = auto_q ^ mode_rise;

    presc_d = presc_q;
    if (clear || mode_rise) begin
      presc_d = '0;
    end else if (auto_q) begin
      presc_d = (presc_q == PreLast) ? '0 : presc_q + 1'b1;
    end

    // Clear wins and drops any request of that cycle; coincident requests merge.
    cnt_d   = cnt_q;
    z_d     = z_q;
    step_d  = 1'b0;
    carry_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
      z_d   = 1'b0;
    end else if (req) begin
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      step_d  = 1'b1;
      carry_d = wrap;
      z_d     = wrap;
    end
  end

  assign bus.cnt       = cnt_q;
  assign bus.step      = step_q;
  assign bus.carry     = carry_q;
  assign bus.z_led     = z_q;
  assign bus.auto_mode = auto_q;

endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// Directed bench for step_sequencer_ctrl with DB_CYCLES=4, AUTO_DIV=8, CNT_MOD=4.
module tb_step_sequencer_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned DIV = 8;
  localparam int unsigned MOD = 4;
  localparam int unsigned W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   step_cnt = 0;
  int   carry_cnt = 0;

  step_sequencer_ctrl_if #(.CNT_W(W)) bus ();

  step_sequencer_ctrl #(
    .DB_CYCLES (DB),
    .AUTO_DIV  (DIV),
    .CNT_MOD   (MOD),
    .CNT_W     (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.step === 1'b1) step_cnt++;
    if (bus.carry === 1'b1) carry_cnt++;
  end

  task automatic test_reset;
    bus.btn_step = 1'b0;
    bus.btn_mode = 1'b0;
    bus.sw_clear = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.cnt !== 2'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", bus.cnt); end
    tests++; if (bus.step !== 1'b0) begin fails++; $display("FAIL reset_step: got %b want 0", bus.step); end
    tests++; if (bus.carry !== 1'b0) begin fails++; $display("FAIL reset_carry: got %b want 0", bus.carry); end
    tests++; if (bus.z_led !== 1'b0) begin fails++; $display("FAIL reset_z_led: got %b want 0", bus.z_led); end
    tests++; if (bus.auto_mode !== 1'b0) begin fails++; $display("FAIL reset_auto: got %b want 0", bus.auto_mode); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tests++; if (step_cnt !== 0) begin fails++; $display("FAIL release_no_step: got %0d steps want 0", step_cnt); end
  endtask

  task automatic test_manual;
    logic [1:0] exp_cnt  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       exp_wrap [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       z_before [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int s0, c0;
    s0 = step_cnt;
    c0 = carry_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (bus.z_led !== z_before[i]) begin fails++; $display("FAIL manual_z_hold[%0d]: got %b want %b", i, bus.z_led, z_before[i]); end
      bus.btn_step = 1'b1;
      repeat (6) @(negedge clk);
      tests++; if (bus.step !== 1'b0) begin fails++; $display("FAIL manual_early[%0d]: got %b want 0", i, bus.step); end
      @(negedge clk);
      tests++; if (bus.step !== 1'b1) begin fails++; $display("FAIL manual_step[%0d]: got %b want 1", i, bus.step); end
      tests++; if (bus.cnt !== exp_cnt[i]) begin fails++; $display("FAIL manual_cnt[%0d]: got %0d want %0d", i, bus.cnt, exp_cnt[i]); end
      tests++; if (bus.carry !== exp_wrap[i]) begin fails++; $display("FAIL manual_carry[%0d]: got %b want %b", i, bus.carry, exp_wrap[i]); end
      tests++; if (bus.z_led !== exp_wrap[i]) begin fails++; $display("FAIL manual_z[%0d]: got %b want %b", i, bus.z_led, exp_wrap[i]); end
      @(negedge clk);
      tests++; if (bus.step !== 1'b0 || bus.carry !== 1'b0) begin fails++; $display("FAIL manual_width[%0d]: got step=%b carry=%b want 0 0", i, bus.step, bus.carry); end
      repeat (12) @(negedge clk);
      bus.btn_step = 1'b0;
      repeat (20) @(negedge clk);
    end
    tests++; if (step_cnt - s0 !== 5) begin fails++; $display("FAIL manual_pulses: got %0d want 5", step_cnt - s0); end
    tests++; if (carry_cnt - c0 !== 1) begin fails++; $display("FAIL manual_carries: got %0d want 1", carry_cnt - c0); end
  endtask

  task automatic test_bounce;
    int s0;
    s0 = step_cnt;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus.btn_step = ((k % 4) < 2);
    end
    @(negedge clk);
    bus.btn_step = 1'b1;
    repeat (20) @(negedge clk);
    bus.btn_step = 1'b0;
    repeat (20) @(negedge clk);
    tests++; if (step_cnt - s0 !== 1) begin fails++; $display("FAIL bounce_pulses: got %0d want 1", step_cnt - s0); end
    tests++; if (bus.cnt !== 2'd2) begin fails++; $display("FAIL bounce_cnt: got %0d want 2", bus.cnt); end
  endtask

  task automatic test_glitch;
    int s0;
    s0 = step_cnt;
    @(negedge clk);
    bus.btn_step = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_step = 1'b0;
    repeat (20) @(negedge clk);
    tests++; if (step_cnt - s0 !== 0) begin fails++; $display("FAIL glitch_pulses: got %0d want 0", step_cnt - s0); end
    tests++; if (bus.cnt !== 2'd2) begin fails++; $display("FAIL glitch_cnt: got %0d want 2", bus.cnt); end
  endtask

  task automatic test_reset_mid_run;
    int s0;
    @(negedge clk);
    tests++; if (bus.cnt !== 2'd2) begin fails++; $display("FAIL midrst_pre_cnt: got %0d want 2", bus.cnt); end
    #2 rst = 1'b1;
    #1;
    tests++; if (bus.cnt !== 2'd0) begin fails++; $display("FAIL midrst_cnt: got %0d want 0", bus.cnt); end
    tests++; if (bus.z_led !== 1'b0) begin fails++; $display("FAIL midrst_z: got %b want 0", bus.z_led); end
    tests++; if (bus.auto_mode !== 1'b0) begin fails++; $display("FAIL midrst_auto: got %b want 0", bus.auto_mode); end
    @(negedge clk);
    rst = 1'b0;
    s0 = step_cnt;
    repeat (10) @(negedge clk);
    tests++; if (step_cnt - s0 !== 0) begin fails++; $display("FAIL midrst_release_step: got %0d want 0", step_cnt - s0); end
    tests++; if (bus.cnt !== 2'd0) begin fails++; $display("FAIL midrst_release_cnt: got %0d want 0", bus.cnt); end
  endtask

  task automatic test_auto;
    logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    int s0, c0;
    s0 = step_cnt;
    c0 = carry_cnt;
    @(negedge clk);
    bus.btn_mode = 1'b1;
    repeat (7) @(negedge clk);
    tests++; if (bus.auto_mode !== 1'b1) begin fails++; $display("FAIL auto_on: got %b want 1", bus.auto_mode); end
    bus.btn_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (7) @(negedge clk);
      tests++; if (bus.step !== 1'b0) begin fails++; $display("FAIL auto_early[%0d]: got %b want 0", i, bus.step); end
      @(negedge clk);
      tests++; if (bus.step !== 1'b1) begin fails++; $display("FAIL auto_step[%0d]: got %b want 1", i, bus.step); end
      tests++; if (bus.cnt !== exp_cnt[i]) begin fails++; $display("FAIL auto_cnt[%0d]: got %0d want %0d", i, bus.cnt, exp_cnt[i]); end
      tests++; if (bus.carry !== (i == 3)) begin fails++; $display("FAIL auto_carry[%0d]: got %b want %b", i, bus.carry, (i == 3)); end
    end
    bus.btn_mode = 1'b1;
    repeat (10) @(negedge clk);
    tests++; if (bus.auto_mode !== 1'b0) begin fails++; $display("FAIL auto_off: got %b want 0", bus.auto_mode); end
    bus.btn_mode = 1'b0;
    repeat (30) @(negedge clk);
    tests++; if (step_cnt - s0 !== 4) begin fails++; $display("FAIL auto_pulses: got %0d want 4", step_cnt - s0); end
    tests++; if (carry_cnt - c0 !== 1) begin fails++; $display("FAIL auto_carries: got %0d want 1", carry_cnt - c0); end
    tests++; if (bus.cnt !== 2'd0) begin fails++; $display("FAIL auto_frozen: got %0d want 0", bus.cnt); end
  endtask

  // Leaves auto mode on with the prescaler phase known to test_clear (tick steps at N23, N31).
  task automatic test_coincidence;
    int s0;
    @(negedge clk);
    bus.btn_mode = 1'b1;
    repeat (7) @(negedge clk);
    bus.btn_mode = 1'b0;
    @(negedge clk);
    s0 = step_cnt;
    bus.btn_step = 1'b1;
    repeat (7) @(negedge clk);
    tests++; if (bus.step !== 1'b1) begin fails++; $display("FAIL coin_step: got %b want 1", bus.step); end
    tests++; if (bus.cnt !== 2'd1) begin fails++; $display("FAIL coin_cnt: got %0d want 1", bus.cnt); end
    @(negedge clk);
    tests++; if (bus.step !== 1'b0 || bus.cnt !== 2'd1) begin fails++; $display("FAIL coin_after: got step=%b cnt=%0d want 0 1", bus.step, bus.cnt); end
    repeat (4) @(negedge clk);
    bus.btn_step = 1'b0;
    tests++; if (step_cnt - s0 !== 1) begin fails++; $display("FAIL coin_pulses: got %0d want 1", step_cnt - s0); end
    repeat (3) @(negedge clk);
    tests++; if (bus.step !== 1'b1 || bus.cnt !== 2'd2) begin fails++; $display("FAIL coin_tick2: got step=%b cnt=%0d want 1 2", bus.step, bus.cnt); end
    repeat (8) @(negedge clk);
    tests++; if (bus.step !== 1'b1 || bus.cnt !== 2'd3) begin fails++; $display("FAIL coin_tick3: got step=%b cnt=%0d want 1 3", bus.step, bus.cnt); end
  endtask

  task automatic test_clear;
    int s0;
    @(negedge clk);
    s0 = step_cnt;
    bus.sw_clear = 1'b1;
    bus.btn_step = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (bus.cnt !== 2'd0) begin fails++; $display("FAIL clear_cnt: got %0d want 0", bus.cnt); end
    tests++; if (bus.z_led !== 1'b0) begin fails++; $display("FAIL clear_z: got %b want 0", bus.z_led); end
    repeat (5) @(negedge clk);
    bus.btn_step = 1'b0;
    repeat (10) @(negedge clk);
    tests++; if (step_cnt - s0 !== 0) begin fails++; $display("FAIL clear_dropped: got %0d steps want 0", step_cnt - s0); end
    tests++; if (bus.cnt !== 2'd0) begin fails++; $display("FAIL clear_hold: got %0d want 0", bus.cnt); end
    tests++; if (bus.auto_mode !== 1'b1) begin fails++; $display("FAIL clear_auto_kept: got %b want 1", bus.auto_mode); end
    bus.sw_clear = 1'b0;
    repeat (9) @(negedge clk);
    tests++; if (bus.step !== 1'b0 || step_cnt - s0 !== 0) begin fails++; $display("FAIL clear_early: got step=%b pulses=%0d want 0 0", bus.step, step_cnt - s0); end
    @(negedge clk);
    tests++; if (bus.step !== 1'b1) begin fails++; $display("FAIL clear_resume_step: got %b want 1", bus.step); end
    tests++; if (bus.cnt !== 2'd1) begin fails++; $display("FAIL clear_resume_cnt: got %0d want 1", bus.cnt); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_bounce();
    test_glitch();
    test_reset_mid_run();
    test_auto();
    test_coincidence();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/step_sequencer_ctrl.md
Name: step_sequencer_ctrl

Overview:
- Controller for the board-level modulo-N state counter: single source of "advance" commands, replacing raw-button edge clocking with one synchronous clock domain.
- Arbitrates two requesters: the debounced manual step button, and an auto-step tick from a prescaler.
- Owns the counter state, wrap/carry flag and mode; outputs drive LEDs directly.

Parameters:
- DB_CYCLES, 1_000_000, clk cycles an input must stay stable before its debounced level changes (10 ms at 100 MHz)
- AUTO_DIV, 100_000_000, clk cycles between auto ticks (1 Hz at 100 MHz)
- CNT_MOD, 4, counter modulus (≥2)
- CNT_W, 2, counter width, = clog2(CNT_MOD)

Ports:
- clk  in  1  board system clock
- rst  in  1  asynchronous, active-high reset
- btn_step  in  1  raw step button, asynchronous, active-high
- btn_mode  in  1  raw mode button, asynchronous, active-high; each press toggles manual/auto
- sw_clear  in  1  slide switch, asynchronous level; high holds counter at 0
- cnt  out  CNT_W  current counter state
- step  out  1  one-cycle pulse, high in the cycle cnt shows its new value
- carry  out  1  one-cycle pulse with step when the step wrapped CNT_MOD-1 → 0
- z_led  out  1  carry held high from wrap until next step or clear
- auto_mode  out  1  1 = auto stepping enabled

Behaviour:
- Reset (async, rst=1): cnt=0, step=0, carry=0, z_led=0, auto_mode=0, prescaler=0, synchronizers/debouncers=0. Release is registered normally; no step on release.
- Inputs: btn_step, btn_mode, sw_clear each pass a 2-FF synchronizer. btn_step/btn_mode then pass a debouncer: the debounced level changes only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count. sw_clear is synchronized only.
- Manual request: 1-cycle pulse on the debounced btn_step rising edge. Release never steps. Holding the button gives exactly one request.
- Mode: debounced btn_mode rising edge toggles auto_mode. Each toggle zeroes the prescaler.
- Prescaler: counts 0..AUTO_DIV-1 only while auto_mode=1 and clear is inactive. On reaching AUTO_DIV-1 it emits an auto request and wraps to 0. First tick comes AUTO_DIV cycles after entering auto.
- Arbitration priority, evaluated each cycle:
  1. clear (sync sw_clear=1): cnt←0, z_led←0, step=0, carry=0, prescaler←0; requests that cycle are dropped, not queued.
  2. Any request (manual OR auto): one step only; coincident requests merge into one.
  3. Otherwise hold.
- Manual requests are honoured in both modes.
- Step edge: cnt←(cnt==CNT_MOD-1)?0:cnt+1; step←1; carry←(old cnt==CNT_MOD-1); z_led←that same wrap value. step and carry drop the next cycle.
- Latency: debounced edge → step high 1 cycle later. Raw press → step after 2 sync + DB_CYCLES + 1 cycles.
- Mode toggle and step in the same cycle: both take effect; the prescaler is zeroed, so that step's source does not matter.
- cnt never takes a value ≥ CNT_MOD. Synthesis and elaboration must fail if CNT_MOD > 2^CNT_W.

Decomposition:
- Shared package step_ctrl_pkg: CNT_W derivation function (clog2), default timing constants CLK_HZ=100_000_000, DB_MS=10.
- One sub-module, debounce_sync: synchronizer + debouncer + rising-edge pulse. Parameter DB_CYCLES. Ports clk, rst, din, level, rise. Instantiated twice (step, mode).
- Arbitration, prescaler and counter stay in the top.

Test Plan (bench uses DB_CYCLES=4, AUTO_DIV=8, CNT_MOD=4):
- Reset mid-run with cnt=2: assert rst asynchronously, no clock edge → cnt=0, z_led=0, auto_mode=0 immediately. Deassert → no step pulse.
- Manual stepping: four clean presses, each held 20 cycles → cnt 1,2,3,0. Exactly 4 step pulses, each 1 cycle wide, 7 cycles after the raw rise. carry only on the 4th; z_led stays 1 until the 5th press.
- Bounce: btn_step toggles 1/0 every 2 cycles for 12 cycles, then stable 1 → exactly one step. A 3-cycle glitch alone → no step.
- Auto mode: press btn_mode → auto_mode=1. Steps every 8 cycles: cnt 0→1→2→3→0, carry on the wrap. Press btn_mode again → stepping stops, cnt frozen.
- Coincidence: manual request aligned to the same cycle as an auto tick → cnt advances by 1 only, a single step pulse.
- Clear priority: sw_clear=1 with the auto tick and a manual press pending → cnt stays 0, no step, prescaler held at 0. Release clear → next auto step occurs 8 cycles later.
